pipe_shifter: RTL and testbench

Parametrised, pipelined barrel shifter: the successor to the 32-bit combinational shifter. Adds configurable data width, right/left rotates, well-defined results for out-of-range amounts and illegal opcodes, and a valid/ready streaming interface with per-stage bubble collapsing. It sits between the execute-stage operand muxes and writeback. Multi-cycle ALU ops can overlap with it, and it can be stalled by the writeback arbiter.

---
 rtl/shifter_pkg.sv | 18 +
 rtl/pipe_shifter_if.sv | 31 +++
 rtl/shift_stage.sv | 30 +++
 rtl/pipe_shifter.sv | 144 ++++++++++++++
 tb/tb_pipe_shifter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: opcode encoding and opcode legality.
package shifter_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        SH_SRL = 3'b000,
        SH_SRA = 3'b001,
        SH_SLL = 3'b010,
        SH_ROR = 3'b011,
        SH_ROL = 3'b100
    } sh_op_e;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= 3'b100);
    endfunction

endpackage

// File: rtl/pipe_shifter_if.sv
// Streaming valid/ready bundle for pipe_shifter: operand beat in, result beat out.
interface pipe_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic [SHW:0]     in_shamt;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

endinterface

// File: rtl/shift_stage.sv
// One combinational log-shift stage: moves data by 2^K positions when enabled, in any of the five modes.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic             en,
    input  sh_op_e           op,
    input  logic             sign,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);
    localparam int D = 1 << K;

    always_comb begin
        data_out = data_in;
        if (en) begin
            case (op)
                SH_SRL:  data_out = data_in >> D;
                SH_SRA:  data_out = {{D{sign}}, data_in[WIDTH-1:D]};
                SH_SLL:  data_out = data_in << D;
                SH_ROR:  data_out = {data_in[D-1:0], data_in[WIDTH-1:D]};
                SH_ROL:  data_out = {data_in[WIDTH-1-D:0], data_in[WIDTH-1:WIDTH-D]};
                default: data_out = data_in;
            endcase
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: SHW log stages split into NREG register slots with per-slot
// valid/ready so empty slots keep absorbing beats while the output is stalled.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int STAGES_PER_CYC = 2,
    parameter int TAG_W          = 5
) (
    input  logic          clk,
    input  logic          rst,
    pipe_shifter_if.slave bus
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int NREG = (SHW + STAGES_PER_CYC - 1) / STAGES_PER_CYC;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shamt;
        sh_op_e           op;
        logic             sign;
        logic [TAG_W-1:0] tag;
        logic             err;
    } payload_t;

    payload_t        pre;
    payload_t        grp_out [NREG];
    payload_t        slot_q  [NREG];
    logic [NREG-1:0] valid_q;
    logic [NREG-1:0] ready;
    logic [NREG-1:0] up_valid;

    function automatic payload_t with_data(input payload_t p, input logic [WIDTH-1:0] d);
        payload_t r;
        r      = p;
        r.data = d;
        return r;
    endfunction

    // Out-of-range amounts are resolved here, so the log stages only ever see in-range shifts.
    always_comb begin
        pre      = '0;
        pre.op   = SH_SRL;
        pre.tag  = bus.in_tag;
        pre.sign = bus.in_data[WIDTH-1];
        if (!is_legal_op(bus.in_op)) begin
            pre.err = 1'b1;
        end else begin
            pre.op    = sh_op_e'(bus.in_op);
            pre.data  = bus.in_data;
            pre.shamt = bus.in_shamt[SHW-1:0];
            if (bus.in_shamt[SHW]) begin
                case (pre.op)
                    SH_SRL, SH_SLL: begin
                        pre.data  = '0;
                        pre.shamt = '0;
                    end
                    SH_SRA: begin
                        pre.data  = {WIDTH{bus.in_data[WIDTH-1]}};
                        pre.shamt = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        localparam int GRP = s / STAGES_PER_CYC;
        payload_t         st_in;
        payload_t         st_out;
        logic [WIDTH-1:0] shifted;

        if (s % STAGES_PER_CYC != 0) begin : g_chain
            assign st_in = g_stage[s-1].st_out;
        end else if (GRP == 0) begin : g_head
            assign st_in = pre;
        end else begin : g_slot
            assign st_in = slot_q[GRP-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .K     (s)
        ) u_stage (
            .en       (st_in.shamt[s]),
            .op       (st_in.op),
            .sign     (st_in.sign),
            .data_in  (st_in.data),
            .data_out (shifted)
        );

        assign st_out = with_data(st_in, shifted);
    end

    for (genvar g = 0; g < NREG; g++) begin : g_group
        localparam int LAST = ((g + 1) * STAGES_PER_CYC < SHW) ? (g + 1) * STAGES_PER_CYC - 1 : SHW - 1;
        assign grp_out[g] = g_stage[LAST].st_out;
    end

    // A slot can take a new beat if it is empty or its occupant moves on this edge.
    always_comb begin
        logic down_ready;
        down_ready = bus.out_ready;
        ready      = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            ready[i]   = !valid_q[i] || down_ready;
            down_ready = ready[i];
        end
    end

    always_comb begin
        up_valid    = '0;
        up_valid[0] = bus.in_valid;
        for (int i = 1; i < NREG; i++) begin
            up_valid[i] = valid_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (ready[i]) begin
                    valid_q[i] <= up_valid[i];
                    if (up_valid[i]) begin
                        slot_q[i] <= grp_out[i];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = valid_q[NREG-1];
    assign bus.out_data  = slot_q[NREG-1].data;
    assign bus.out_tag   = slot_q[NREG-1].tag;
    assign bus.out_err   = slot_q[NREG-1].err;

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter: expected results are queued on acceptance and
// compared in order as results leave the pipeline.
module tb_pipe_shifter;

    localparam int WIDTH = 32;
    localparam int SPC   = 2;
    localparam int TAG_W = 5;
    localparam int SHW   = $clog2(WIDTH);
    localparam int NREG  = (SHW + SPC - 1) / SPC;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic clk;
    logic rst;

    pipe_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    pipe_shifter #(
        .WIDTH          (WIDTH),
        .STAGES_PER_CYC (SPC),
        .TAG_W          (TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t             sb_q[$];
    exp_t             pending;
    int               checks;
    int               errors;
    int               cyc;
    int               out_count;
    int               last_out_cyc;
    int               prev_out_cyc;
    logic             in_fire;
    logic             stall_prev;
    logic [WIDTH-1:0] held_data;
    logic [TAG_W-1:0] held_tag;
    logic             held_err;

    function automatic logic [WIDTH-1:0] ref_shift(input logic [2:0] op, input logic [WIDTH-1:0] d,
                                                   input logic [SHW:0] sh);
        logic signed [WIDTH-1:0] sd;
        int                      r;
        sd        = d;
        r         = int'(sh) % WIDTH;
        ref_shift = '0;
        case (op)
            3'd0: if (sh < WIDTH) ref_shift = d >> sh;
            3'd1: if (sh < WIDTH) ref_shift = sd >>> sh; else ref_shift = {WIDTH{d[WIDTH-1]}};
            3'd2: if (sh < WIDTH) ref_shift = d << sh;
            3'd3: ref_shift = (d >> r) | (d << (WIDTH - r));
            3'd4: ref_shift = (d << r) | (d >> (WIDTH - r));
            default: ref_shift = '0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        exp_t e;
        #1;
        if (stall_prev && bus.out_valid) begin
            checkOutput("hold_data", bus.out_data, held_data);
            checkOutput("hold_tag", bus.out_tag, held_tag);
            checkOutput("hold_err", bus.out_err, held_err);
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held_data  = bus.out_data;
        held_tag   = bus.out_tag;
        held_err   = bus.out_err;
        in_fire    = bus.in_valid && bus.in_ready;
        if (in_fire) sb_q.push_back(pending);
        if (bus.out_valid && bus.out_ready) begin
            out_count++;
            prev_out_cyc = last_out_cyc;
            last_out_cyc = cyc;
            if (sb_q.size() == 0) begin
                checkOutput("spurious_out", 1, 0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("out_data", bus.out_data, e.data);
                checkOutput("out_tag", bus.out_tag, e.tag);
                checkOutput("out_err", bus.out_err, e.err);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic setBeat(input logic [2:0] op, input logic [WIDTH-1:0] data, input logic [SHW:0] shamt,
                           input logic [TAG_W-1:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = data;
        bus.in_shamt = shamt;
        bus.in_tag   = tag;
        pending.data = ref_shift(op, data, shamt);
        pending.tag  = tag;
        pending.err  = (op > 3'd4);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] data, input logic [SHW:0] shamt,
                                 input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp_data, input logic exp_err);
        int guard;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = data;
        bus.in_shamt = shamt;
        bus.in_tag   = tag;
        pending.data = exp_data;
        pending.tag  = tag;
        pending.err  = exp_err;
        guard        = 0;
        do begin
            step();
            guard++;
        end while (!in_fire && guard < 100);
        if (!in_fire) checkOutput("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            step();
            guard++;
        end
        if (sb_q.size() != 0) checkOutput("drain_timeout", sb_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int               lat;
        int               sent;
        int               accepted;
        int               base;
        logic [WIDTH-1:0] bp_data [6];

        checks       = 0;
        errors       = 0;
        cyc          = 0;
        out_count    = 0;
        last_out_cyc = -10;
        prev_out_cyc = -20;
        in_fire      = 1'b0;
        stall_prev   = 1'b0;
        held_data    = '0;
        held_tag     = '0;
        held_err     = 1'b0;
        pending      = '0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_data  = '0;
        bus.in_shamt = '0;
        bus.in_tag   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_out_data", bus.out_data, 0);
        checkOutput("reset_out_tag", bus.out_tag, 0);
        checkOutput("reset_out_err", bus.out_err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", bus.in_ready, 1);

        // SRA with exact latency
        bus.out_ready = 1'b1;
        applyStimulus(3'b001, 32'h8000_0000, 6'd4, 5'd1, 32'hF800_0000, 1'b0);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        checkOutput("sra_latency", lat, NREG);
        drain();

        // ROR then ROL back-to-back
        applyStimulus(3'b011, 32'h1234_5678, 6'd8, 5'd3, 32'h7812_3456, 1'b0);
        applyStimulus(3'b100, 32'h8000_0001, 6'd1, 5'd4, 32'h0000_0003, 1'b0);
        drain();
        checkOutput("b2b_spacing", last_out_cyc - prev_out_cyc, 1);

        // Range edge cases and illegal opcode
        applyStimulus(3'b010, 32'hFFFF_FFFF, 6'd32, 5'd5, 32'h0000_0000, 1'b0);
        applyStimulus(3'b001, 32'h8000_0000, 6'd40, 5'd6, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(3'b011, 32'h0000_0002, 6'd33, 5'd7, 32'h0000_0001, 1'b0);
        applyStimulus(3'b110, 32'h1234_5678, 6'd3, 5'd8, 32'h0000_0000, 1'b1);
        applyStimulus(3'b000, 32'h8000_0000, 6'd63, 5'd10, 32'h0000_0000, 1'b0);
        applyStimulus(3'b100, 32'h8000_0000, 6'd33, 5'd11, 32'h0000_0001, 1'b0);
        applyStimulus(3'b001, 32'h7000_0000, 6'd36, 5'd12, 32'h0000_0000, 1'b0);
        drain();

        // Backpressure: six beats against a stalled output
        for (int i = 0; i < 6; i++) bp_data[i] = $urandom;
        bus.out_ready = 1'b0;
        sent          = 0;
        base          = out_count;
        for (int c = 0; c < 5; c++) begin
            setBeat(3'(sent % 5), bp_data[sent], 6'(3 * sent + 1), 5'(16 + sent));
            step();
            if (in_fire) sent++;
        end
        checkOutput("bp_accepts", sent, NREG);
        checkOutput("bp_in_ready_low", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 50 && sent < 6; c++) begin
            setBeat(3'(sent % 5), bp_data[sent], 6'(3 * sent + 1), 5'(16 + sent));
            step();
            if (in_fire) sent++;
        end
        bus.in_valid = 1'b0;
        drain();
        checkOutput("bp_out_count", out_count - base, 6);

        // Bubble collapse: idle cycle inside a stalled stream
        bus.out_ready = 1'b0;
        applyStimulus(3'b000, 32'hF0F0_F0F0, 6'd4, 5'd20, 32'h0F0F_0F0F, 1'b0);
        step();
        accepted = 1;
        for (int c = 0; c < 6; c++) begin
            setBeat(3'b010, 32'h0000_0001, 6'(accepted), 5'(20 + accepted));
            step();
            if (in_fire) accepted++;
        end
        checkOutput("bubble_fill", accepted, NREG);
        checkOutput("bubble_in_ready_low", bus.in_ready, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Reset while beats are in flight
        bus.out_ready = 1'b0;
        applyStimulus(3'b000, 32'hFFFF_FFFF, 6'd0, 5'd24, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(3'b000, 32'hFFFF_FFFF, 6'd0, 5'd25, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(3'b000, 32'hFFFF_FFFF, 6'd0, 5'd26, 32'hFFFF_FFFF, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", bus.out_valid, 0);
        checkOutput("rst_mid_out_data", bus.out_data, 0);
        checkOutput("rst_mid_out_tag", bus.out_tag, 0);
        sb_q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        base          = out_count;
        bus.out_ready = 1'b1;
        applyStimulus(3'b010, 32'h0000_0001, 6'd31, 5'd27, 32'h8000_0000, 1'b0);
        drain();
        repeat (4) step();
        checkOutput("rst_no_stale", out_count - base, 1);

        // Random traffic with random backpressure
        sent = 0;
        for (int c = 0; c < 400 && sent < 40; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                setBeat(3'($urandom_range(0, 7)), $urandom, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)));
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            if (in_fire) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
